// File: rtl/sfx_event_queue.sv
// Sound-effect event queue: three collision inputs become EAT/HIT/DIE events.
// EAT and HIT are queued in a small FIFO. DIE flushes the queue and pre-empts
// the current sound. Playback advances only on frame_end, one sound at a time.
module sfx_event_queue #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned DUR_EAT    = 8,
   parameter int unsigned DUR_HIT    = 4,
   parameter int unsigned DUR_DIE    = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_end,
   input  logic       sheep_dragon_col,
   input  logic       sword_dragon_col,
   input  logic       player_dragon_col,
   output logic       eat_sound,
   output logic       hit_sound,
   output logic       die_sound,
   output logic       busy,
   output logic [3:0] fifo_count,
   output logic       overflow
);

   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [1:0] CODE_EAT = 2'd1;
   localparam logic [1:0] CODE_HIT = 2'd2;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_PLAY = 1'b1
   } state_t;

   // Frame count minus one for a queued sound code (only EAT or HIT is ever queued).
   function automatic logic [7:0] dur_of(input logic [1:0] code);
      logic [7:0] d;
      case (code)
         CODE_HIT: d = 8'(DUR_HIT - 1);
         CODE_EAT: d = 8'(DUR_EAT - 1);
         default:  d = 8'(DUR_EAT - 1);
      endcase
      return d;
   endfunction

   // Bit 0 = EAT (sheep), bit 1 = HIT (sword), bit 2 = DIE (player).
   logic [2:0]    sync1_r;
   logic [2:0]    sync2_r;
   logic [2:0]    prev_r;
   logic [2:0]    evt_r;

   logic [1:0]    mem_r [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [3:0]    count_r;
   logic          overflow_r;

   state_t        state_r;
   logic [7:0]    counter_r;
   logic          eat_r;
   logic          hit_r;
   logic          die_r;
   logic          die_pending_r;
   logic          die_lock_r;

   logic          die_evt_s;
   logic          hit_evt_s;
   logic          eat_evt_s;
   logic          push_req_s;
   logic          full_s;
   logic          push_s;
   logic          drop_s;
   logic [1:0]    push_code_s;
   logic          pop_s;
   logic [1:0]    head_code_s;

   // Synchronize the asynchronous collision levels and register a one-cycle rising-edge pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_r <= 3'b000;
         sync2_r <= 3'b000;
         prev_r  <= 3'b000;
         evt_r   <= 3'b000;
      end else begin
         sync1_r <= {player_dragon_col, sword_dragon_col, sheep_dragon_col};
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
         evt_r   <= sync2_r & ~prev_r;
      end
   end

   // Priority resolution, FIFO push/drop decision and pop decision from pre-update state.
   always_comb begin
      die_evt_s   = evt_r[2];
      hit_evt_s   = evt_r[1] & ~evt_r[2];
      eat_evt_s   = evt_r[0] & ~evt_r[1] & ~evt_r[2];
      push_req_s  = (hit_evt_s | eat_evt_s) & ~die_lock_r;
      full_s      = (count_r == 4'(FIFO_DEPTH));
      push_s      = push_req_s & ~full_s;
      drop_s      = push_req_s & full_s;
      push_code_s = hit_evt_s ? CODE_HIT : CODE_EAT;
      pop_s       = frame_end & ~die_pending_r & (count_r != 4'd0) &
                    ((state_r == ST_IDLE) | (counter_r == 8'd0));
      head_code_s = mem_r[rd_ptr_r];
   end

   // Event FIFO storage, pointers and occupancy; a DIE event flushes everything.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            mem_r[i] <= 2'd0;
         end
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         count_r    <= 4'd0;
         overflow_r <= 1'b0;
      end else begin
         overflow_r <= drop_s;
         if (die_evt_s) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= 4'd0;
         end else begin
            if (push_s) begin
               mem_r[wr_ptr_r] <= push_code_s;
               wr_ptr_r        <= wr_ptr_r + PW'(1);
            end else begin
               wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
               rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
               rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
               2'b10:   count_r <= count_r + 4'd1;
               2'b01:   count_r <= count_r - 4'd1;
               default: count_r <= count_r;
            endcase
         end
      end
   end

   // Playback state machine: every transition and output change happens on frame_end.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r       <= ST_IDLE;
         counter_r     <= 8'd0;
         eat_r         <= 1'b0;
         hit_r         <= 1'b0;
         die_r         <= 1'b0;
         die_pending_r <= 1'b0;
         die_lock_r    <= 1'b0;
      end else begin
         if (die_evt_s) begin
            die_pending_r <= 1'b1;
         end else if (frame_end) begin
            die_pending_r <= 1'b0;
         end else begin
            die_pending_r <= die_pending_r;
         end

         if (frame_end) begin
            if (die_pending_r) begin
               state_r    <= ST_PLAY;
               counter_r  <= 8'(DUR_DIE - 1);
               eat_r      <= 1'b0;
               hit_r      <= 1'b0;
               die_r      <= 1'b1;
               die_lock_r <= 1'b1;
            end else if (pop_s) begin
               state_r    <= ST_PLAY;
               counter_r  <= dur_of(head_code_s);
               eat_r      <= (head_code_s == CODE_EAT);
               hit_r      <= (head_code_s == CODE_HIT);
               die_r      <= 1'b0;
               die_lock_r <= 1'b0;
            end else if ((state_r == ST_PLAY) && (counter_r != 8'd0)) begin
               counter_r <= counter_r - 8'd1;
            end else begin
               state_r    <= ST_IDLE;
               counter_r  <= 8'd0;
               eat_r      <= 1'b0;
               hit_r      <= 1'b0;
               die_r      <= 1'b0;
               die_lock_r <= 1'b0;
            end
         end else begin
            state_r <= state_r;
         end
      end
   end

   assign eat_sound  = eat_r;
   assign hit_sound  = hit_r;
   assign die_sound  = die_r;
   assign busy       = (state_r == ST_PLAY);
   assign fifo_count = count_r;
   assign overflow   = overflow_r;

endmodule

// File: tb/tb_sfx_event_queue.sv
// Bench for sfx_event_queue: directed scenarios plus a randomized run compared
// cycle by cycle against a transaction-level reference model (sound queue,
// frames-remaining counter, pending/lock flags).
module tb_sfx_event_queue;

   localparam int DEPTH = 4;
   localparam int D_EAT = 8;
   localparam int D_HIT = 4;
   localparam int D_DIE = 32;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       frame_end;
   logic       sheep_dragon_col;
   logic       sword_dragon_col;
   logic       player_dragon_col;
   logic       eat_sound;
   logic       hit_sound;
   logic       die_sound;
   logic       busy;
   logic [3:0] fifo_count;
   logic       overflow;

   int checks = 0;
   int errors = 0;

   // {player, sword, sheep}
   bit [2:0] cols;

   // Reference model: queued codes (1 EAT, 2 HIT), current sound (0 none, 3 DIE),
   // frames left in the current sound, plus input history for edge latency.
   int       mq[$];
   int       m_cur;
   int       m_rem;
   bit       m_dpend;
   bit       m_lock;
   bit       m_ovf;
   bit [2:0] m_hist[4];

   sfx_event_queue #(
      .FIFO_DEPTH(DEPTH), .DUR_EAT(D_EAT), .DUR_HIT(D_HIT), .DUR_DIE(D_DIE)
   ) dut (
      .clk(clk), .rst_n(rst_n), .frame_end(frame_end),
      .sheep_dragon_col(sheep_dragon_col), .sword_dragon_col(sword_dragon_col),
      .player_dragon_col(player_dragon_col),
      .eat_sound(eat_sound), .hit_sound(hit_sound), .die_sound(die_sound),
      .busy(busy), .fifo_count(fifo_count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   function automatic int dur(input int code);
      case (code)
         1:       return D_EAT;
         2:       return D_HIT;
         default: return D_DIE;
      endcase
   endfunction

   task automatic model_step(input bit fe, input bit [2:0] col, input bit rn);
      bit [2:0] ev;
      bit       is_die, is_hit, is_eat, old_lock, old_dpend;
      int       old_size;
      if (!rn) begin
         mq.delete();
         m_cur = 0; m_rem = 0; m_dpend = 0; m_lock = 0; m_ovf = 0;
         for (int k = 0; k < 4; k++) m_hist[k] = 3'b000;
         return;
      end
      // An input high at edge n (and low at n-1) is acted on at edge n+3.
      ev = m_hist[2] & ~m_hist[3];
      m_hist[3] = m_hist[2]; m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0]; m_hist[0] = col;
      is_die = ev[2];
      is_hit = ev[1] && !is_die;
      is_eat = ev[0] && !ev[1] && !ev[2];
      old_size = mq.size(); old_lock = m_lock; old_dpend = m_dpend;
      m_ovf = 0;
      if (fe) begin
         if (old_dpend) begin
            m_cur = 3; m_rem = D_DIE; m_lock = 1;
         end else if (m_cur != 0 && m_rem > 1) begin
            m_rem--;
         end else if (old_size > 0) begin
            m_cur = mq.pop_front(); m_rem = dur(m_cur); m_lock = 0;
         end else begin
            m_cur = 0; m_rem = 0; m_lock = 0;
         end
      end
      if (is_die) mq.delete();
      else if ((is_hit || is_eat) && !old_lock) begin
         if (old_size >= DEPTH) m_ovf = 1;
         else mq.push_back(is_hit ? 2 : 1);
      end
      if (is_die) m_dpend = 1;
      else if (fe) m_dpend = 0;
   endtask

   task automatic tick(input bit fe, input bit rn = 1'b1);
      frame_end = fe;
      rst_n = rn;
      {player_dragon_col, sword_dragon_col, sheep_dragon_col} = cols;
      @(posedge clk);
      model_step(fe, cols, rn);
      #1;
   endtask

   task automatic test_reset;
      cols = 3'b000;
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      checks++;
      if ({eat_sound, hit_sound, die_sound, busy, overflow} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 00000",
                  {eat_sound, hit_sound, die_sound, busy, overflow});
      end
      checks++;
      if (fifo_count !== 4'd0) begin
         errors++;
         $display("FAIL reset_count: got %0d expected 0", fifo_count);
      end
   endtask

   task automatic test_single_eat;
      int eat_frames;
      eat_frames = 0;
      tick(1'b0, 1'b0);
      cols = 3'b001;
      repeat (3) tick(1'b0);
      checks++;
      if (fifo_count !== 4'd0) begin
         errors++;
         $display("FAIL eat_latency_early: got %0d expected 0", fifo_count);
      end
      tick(1'b0);
      checks++;
      if (fifo_count !== 4'd1) begin
         errors++;
         $display("FAIL eat_latency: got %0d expected 1", fifo_count);
      end
      repeat (95) tick(1'b0);
      for (int f = 0; f < 12; f++) begin
         if (f > 0) repeat (99) tick(1'b0);
         tick(1'b1);
         if (eat_sound === 1'b1) eat_frames++;
      end
      checks++;
      if (eat_frames != 8) begin
         errors++;
         $display("FAIL eat_frames: got %0d expected 8", eat_frames);
      end
      checks++;
      if ({busy, eat_sound, fifo_count} !== 6'b000000) begin
         errors++;
         $display("FAIL eat_idle: got busy=%b eat=%b cnt=%0d expected 0 0 0",
                  busy, eat_sound, fifo_count);
      end
      cols = 3'b000;
   endtask

   task automatic test_back_to_back;
      int ovf_cnt, hit_cycles, gaps;
      ovf_cnt = 0; hit_cycles = 0; gaps = 0;
      cols = 3'b000;
      tick(1'b0, 1'b0);
      for (int e = 0; e < 5; e++) begin
         cols = 3'b010;
         repeat (3) begin tick(1'b0); if (overflow === 1'b1) ovf_cnt++; end
         cols = 3'b000;
         repeat (3) begin tick(1'b0); if (overflow === 1'b1) ovf_cnt++; end
      end
      repeat (2) begin tick(1'b0); if (overflow === 1'b1) ovf_cnt++; end
      checks++;
      if (fifo_count !== 4'd4) begin
         errors++;
         $display("FAIL full_count: got %0d expected 4", fifo_count);
      end
      checks++;
      if (ovf_cnt != 1) begin
         errors++;
         $display("FAIL overflow_pulses: got %0d expected 1", ovf_cnt);
      end
      for (int f = 0; f < 16; f++) begin
         tick(1'b1);
         if (hit_sound === 1'b1) hit_cycles++; else gaps++;
         repeat (3) begin
            tick(1'b0);
            if (hit_sound === 1'b1) hit_cycles++; else gaps++;
         end
      end
      checks++;
      if (gaps != 0 || hit_cycles != 64) begin
         errors++;
         $display("FAIL hit_back_to_back: got %0d high %0d gap cycles expected 64 0",
                  hit_cycles, gaps);
      end
      tick(1'b1);
      checks++;
      if ({hit_sound, busy, fifo_count} !== 6'b000000) begin
         errors++;
         $display("FAIL hit_end_idle: got hit=%b busy=%b cnt=%0d expected 0 0 0",
                  hit_sound, busy, fifo_count);
      end
   endtask

   task automatic test_die_abort;
      int die_frames, bad;
      die_frames = 0; bad = 0;
      cols = 3'b000;
      tick(1'b0, 1'b0);
      cols = 3'b001;
      repeat (4) tick(1'b0);
      tick(1'b1);
      checks++;
      if (eat_sound !== 1'b1) begin
         errors++;
         $display("FAIL die_pre_eat: got %b expected 1", eat_sound);
      end
      repeat (2) begin
         cols = 3'b011; repeat (3) tick(1'b0);
         cols = 3'b001; repeat (3) tick(1'b0);
      end
      checks++;
      if (fifo_count !== 4'd2) begin
         errors++;
         $display("FAIL die_pre_count: got %0d expected 2", fifo_count);
      end
      cols = 3'b101;
      repeat (3) tick(1'b0);
      checks++;
      if (fifo_count !== 4'd2) begin
         errors++;
         $display("FAIL die_flush_early: got %0d expected 2", fifo_count);
      end
      tick(1'b0);
      checks++;
      if (fifo_count !== 4'd0) begin
         errors++;
         $display("FAIL die_flush: got %0d expected 0", fifo_count);
      end
      repeat (2) tick(1'b0);
      checks++;
      if ({eat_sound, die_sound} !== 2'b10) begin
         errors++;
         $display("FAIL die_wait_frame: got eat,die=%b expected 10", {eat_sound, die_sound});
      end
      tick(1'b1);
      checks++;
      if ({eat_sound, hit_sound, die_sound} !== 3'b001) begin
         errors++;
         $display("FAIL die_start: got %b expected 001", {eat_sound, hit_sound, die_sound});
      end
      if (die_sound === 1'b1) die_frames++;
      for (int f = 1; f < 40; f++) begin
         cols = {1'b1, (f < 30) && (f % 2 == 1), 1'b1};
         repeat (3) begin
            tick(1'b0);
            if (fifo_count !== 4'd0 || overflow !== 1'b0) bad++;
         end
         tick(1'b1);
         if (fifo_count !== 4'd0 || overflow !== 1'b0) bad++;
         if (die_sound === 1'b1) die_frames++;
      end
      checks++;
      if (die_frames != 32) begin
         errors++;
         $display("FAIL die_frames: got %0d expected 32", die_frames);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL die_lock_ignore: got %0d bad cycles expected 0", bad);
      end
      cols = 3'b000;
   endtask

   task automatic test_simultaneous;
      int bad;
      bad = 0;
      cols = 3'b000;
      tick(1'b0, 1'b0);
      cols = 3'b111;
      repeat (8) begin
         tick(1'b0);
         if (fifo_count !== 4'd0 || overflow !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL simul_queue: got %0d bad cycles expected 0", bad);
      end
      tick(1'b1);
      checks++;
      if ({eat_sound, hit_sound, die_sound, busy} !== 4'b0011) begin
         errors++;
         $display("FAIL simul_die: got %b expected 0011",
                  {eat_sound, hit_sound, die_sound, busy});
      end
      cols = 3'b000;
   endtask

   task automatic test_reset_mid;
      cols = 3'b000;
      tick(1'b0, 1'b0);
      repeat (3) begin
         cols = 3'b010; repeat (3) tick(1'b0);
         cols = 3'b000; repeat (3) tick(1'b0);
      end
      tick(1'b1);
      repeat (2) tick(1'b0);
      checks++;
      if ({hit_sound, fifo_count} !== 5'b10010) begin
         errors++;
         $display("FAIL mid_pre: got hit=%b cnt=%0d expected 1 2", hit_sound, fifo_count);
      end
      tick(1'b0, 1'b0);
      checks++;
      if ({eat_sound, hit_sound, die_sound, busy, overflow, fifo_count} !== 9'd0) begin
         errors++;
         $display("FAIL mid_reset: got %b cnt=%0d expected all 0",
                  {eat_sound, hit_sound, die_sound, busy, overflow}, fifo_count);
      end
   endtask

   task automatic test_held_input;
      cols = 3'b010;
      tick(1'b0, 1'b0);
      repeat (3) tick(1'b0);
      checks++;
      if (fifo_count !== 4'd0) begin
         errors++;
         $display("FAIL held_early: got %0d expected 0", fifo_count);
      end
      tick(1'b0);
      repeat (10) tick(1'b0);
      checks++;
      if (fifo_count !== 4'd1) begin
         errors++;
         $display("FAIL held_one_event: got %0d expected 1", fifo_count);
      end
      cols = 3'b000;
   endtask

   task automatic test_random;
      bit fe, rn;
      bit [5:0] exp_v;
      cols = 3'b000;
      tick(1'b0, 1'b0);
      for (int c = 0; c < 5000; c++) begin
         for (int b = 0; b < 3; b++) begin
            if ($urandom_range(0, 11) == 0) cols[b] = ~cols[b];
         end
         if (cols[2] && $urandom_range(0, 3) != 0) cols[2] = 1'b0;
         fe = ($urandom_range(0, 2) == 0);
         rn = ($urandom_range(0, 799) != 0);
         tick(fe, rn);
         exp_v = {m_cur == 1, m_cur == 2, m_cur == 3, m_cur != 0, m_ovf, 1'b0};
         checks++;
         if ({eat_sound, hit_sound, die_sound, busy, overflow, 1'b0} !== exp_v) begin
            errors++;
            $display("FAIL rand_out cyc %0d: got eat,hit,die,busy,ovf=%b expected %b",
                     c, {eat_sound, hit_sound, die_sound, busy, overflow}, exp_v[5:1]);
         end
         checks++;
         if (fifo_count !== 4'(mq.size())) begin
            errors++;
            $display("FAIL rand_count cyc %0d: got %0d expected %0d", c, fifo_count, mq.size());
         end
         checks++;
         if ((32'(eat_sound) + 32'(hit_sound) + 32'(die_sound)) > 1) begin
            errors++;
            $display("FAIL rand_onehot cyc %0d: got %b expected at most one",
                     c, {eat_sound, hit_sound, die_sound});
         end
      end
   endtask

   initial begin
      cols = 3'b000;
      rst_n = 1'b0;
      frame_end = 1'b0;
      {player_dragon_col, sword_dragon_col, sheep_dragon_col} = 3'b000;
      test_reset();
      test_single_eat();
      test_back_to_back();
      test_die_abort();
      test_simultaneous();
      test_reset_mid();
      test_held_input();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
